// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-stream transmit and receive blocks:
// nibble width, default frame length and the serializer FSM states.
package nibble_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int NIBBLES_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_stream_tx_hold_buf.sv
// Single-entry valid/ready holding register in front of the serializer.
// A drain and a new acceptance in the same cycle leave the buffer full.
module nibble_hold_buf
    import nibble_pkg::*;
#(
    parameter int WIDTH = NIBBLE_W * NIBBLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             drain,
    output logic             hold_v,
    output logic [WIDTH-1:0] hold_data
);

    logic             hold_v_q;
    logic             hold_v_d;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;
    logic             accept;

    always_comb begin
        in_ready = ~hold_v_q & ~rst;
        accept   = in_valid & in_ready;
        hold_v_d = hold_v_q;
        if (drain) begin
            hold_v_d = 1'b0;
        end
        // Acceptance wins over drain so a word arriving on the load cycle is kept.
        if (accept) begin
            hold_v_d = 1'b1;
        end
        hold_d = accept ? in_data : hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v_q <= 1'b0;
        end else begin
            hold_v_q <= hold_v_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign hold_v    = hold_v_q;
    assign hold_data = hold_q;

endmodule

// File: rtl/nibble_stream_tx.sv
// Frame serializer: unpacks a word of NIBBLES 4-bit values, most significant
// nibble first, onto the en/num strobe interface with an inter-frame gap.
module nibble_stream_tx
    import nibble_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF,
    parameter int GAP     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_data,
    output logic                        in_ready,
    output logic                        en,
    output logic [NIBBLE_W-1:0]         num,
    output logic                        busy,
    output logic                        done,
    output logic [7:0]                  frame_cnt
);

    localparam int W      = NIBBLE_W * NIBBLES;
    localparam int IDX_W  = cnt_w(NIBBLES);
    localparam int GCNT_W = cnt_w(GAP);

    state_e              state_q;
    state_e              state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [GCNT_W-1:0]   gcnt_q;
    logic [GCNT_W-1:0]   gcnt_d;
    logic [W-1:0]        shreg_q;
    logic [W-1:0]        shreg_d;
    logic                en_q;
    logic                en_d;
    logic [NIBBLE_W-1:0] num_q;
    logic [NIBBLE_W-1:0] num_d;
    logic                last_q;
    logic                last_d;
    logic                done_q;
    logic                done_d;
    logic [7:0]          frame_cnt_q;
    logic [7:0]          frame_cnt_d;

    logic                drain;
    logic                hold_v;
    logic [W-1:0]        hold_data;
    logic                last_nib;

    nibble_hold_buf #(
        .WIDTH (W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .drain     (drain),
        .hold_v    (hold_v),
        .hold_data (hold_data)
    );

    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            gcnt_q      <= '0;
            en_q        <= 1'b0;
            num_q       <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gcnt_q      <= gcnt_d;
            en_q        <= en_d;
            num_q       <= num_d;
            last_q      <= last_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        shreg_d = shreg_q;
        drain   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_v) begin
                    drain   = 1'b1;
                    shreg_d = hold_data;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                shreg_d = shreg_q << NIBBLE_W;
                idx_d   = idx_q + IDX_W'(1);
                if (last_nib) begin
                    idx_d = '0;
                    if (GAP > 0) begin
                        gcnt_d  = GCNT_W'(GAP - 1);
                        state_d = ST_GAP;
                    end else if (hold_v) begin
                        // Zero gap: chain straight into the queued frame.
                        drain   = 1'b1;
                        shreg_d = hold_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                gcnt_d = gcnt_q - GCNT_W'(1);
                if (gcnt_q == '0) begin
                    if (hold_v) begin
                        drain   = 1'b1;
                        shreg_d = hold_data;
                        idx_d   = '0;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered one cycle behind the state that produces them.
    always_comb begin
        en_d        = (state_q == ST_SEND);
        num_d       = en_d ? shreg_q[W-1 -: NIBBLE_W] : '0;
        last_d      = en_d & last_nib;
        done_d      = last_q;
        frame_cnt_d = frame_cnt_q + {7'd0, last_q};
    end

    assign en        = en_q;
    assign num       = num_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != ST_IDLE) | hold_v;

endmodule

// File: tb/tb_nibble_stream_tx.sv
// Bench for nibble_stream_tx: a GAP=4 and a GAP=0 instance checked every
// cycle against a frame-schedule reference model.
module tb_nibble_stream_tx;

    localparam int N = 10;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] w;
        int           a;
        int           s;
    } frame_t;

    logic         clk;
    logic         rst;
    logic         iv     [2];
    logic [W-1:0] idata  [2];
    logic         rdy    [2];
    logic         en     [2];
    logic [3:0]   num    [2];
    logic         busy   [2];
    logic         done   [2];
    logic [7:0]   fcnt   [2];

    frame_t       fq     [2][$];
    logic [W-1:0] src    [2][$];
    int           last_l [2];
    int           mfcnt  [2];
    bit           mrdy   [2];
    int           ndone  [2];
    int           cyc;
    bit           gate_rand;
    int           ncmp;
    int           nfail;

    nibble_stream_tx #(.NIBBLES(N), .GAP(4)) dut_g4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idata[0]), .in_ready(rdy[0]),
        .en(en[0]), .num(num[0]), .busy(busy[0]), .done(done[0]), .frame_cnt(fcnt[0])
    );

    nibble_stream_tx #(.NIBBLES(N), .GAP(0)) dut_g0 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idata[1]), .in_ready(rdy[1]),
        .en(en[1]), .num(num[1]), .busy(busy[1]), .done(done[1]), .frame_cnt(fcnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cmp=%0d", ncmp);
        $fatal(1, "watchdog");
    end

    function automatic int gap_of(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            fq[d].delete();
            src[d].delete();
            last_l[d] = -1000;
            mfcnt[d]  = 0;
            mrdy[d]   = 1'b0;
        end
    endtask

    // Expected outputs derived from the frame schedule (accept time a, first nibble time s).
    task automatic expect_out(input int d);
        logic       xen, xdone, xrdy, xbusy;
        logic [3:0] xnum;
        int         g;
        frame_t     f;
        g = gap_of(d);
        xen = 1'b0; xnum = '0; xdone = 1'b0; xrdy = 1'b1; xbusy = 1'b0;
        for (int i = 0; i < fq[d].size(); i++) begin
            f = fq[d][i];
            if (cyc >= f.s && cyc <= f.s + N - 1) begin
                xen  = 1'b1;
                xnum = f.w[W-1-4*(cyc-f.s) -: 4];
            end
            if (cyc == f.s + N) xdone = 1'b1;
            if (cyc >= f.a && cyc <= f.s - 2) begin
                xrdy  = 1'b0;
                xbusy = 1'b1;
            end
            if (cyc >= f.s - 1 && cyc <= f.s + N - 2 + g) xbusy = 1'b1;
        end
        if (xdone) mfcnt[d] = (mfcnt[d] + 1) % 256;
        while (fq[d].size() > 0 && cyc > fq[d][0].s + N + g) void'(fq[d].pop_front());
        mrdy[d] = xrdy;
        if (done[d] === 1'b1) ndone[d]++;
        chk($sformatf("g%0d.en", gap_of(d)), 64'(en[d]), 64'(xen));
        chk($sformatf("g%0d.num", gap_of(d)), 64'(num[d]), 64'(xnum));
        chk($sformatf("g%0d.done", gap_of(d)), 64'(done[d]), 64'(xdone));
        chk($sformatf("g%0d.in_ready", gap_of(d)), 64'(rdy[d]), 64'(xrdy));
        chk($sformatf("g%0d.busy", gap_of(d)), 64'(busy[d]), 64'(xbusy));
        chk($sformatf("g%0d.frame_cnt", gap_of(d)), 64'(fcnt[d]), 64'(mfcnt[d]));
    endtask

    task automatic step();
        int s;
        for (int d = 0; d < 2; d++) begin
            iv[d]    = (src[d].size() > 0) && (!gate_rand || ($urandom_range(0, 3) != 0));
            idata[d] = (src[d].size() > 0) ? src[d][0] : '0;
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (iv[d] && mrdy[d]) begin
                s = (cyc + 2 > last_l[d] + gap_of(d) + 1) ? cyc + 2 : last_l[d] + gap_of(d) + 1;
                fq[d].push_back('{w: src[d][0], a: cyc, s: s});
                last_l[d] = s + N - 1;
                void'(src[d].pop_front());
            end
        end
        #1;
        for (int d = 0; d < 2; d++) expect_out(d);
    endtask

    task automatic drain(input int budget);
        int  n;
        bit  empty;
        n = 0;
        empty = 1'b0;
        while (!empty && n < budget) begin
            step();
            n++;
            empty = (src[0].size() == 0) && (src[1].size() == 0) &&
                    (fq[0].size() == 0) && (fq[1].size() == 0);
        end
        chk("drain_done", 64'(empty), 64'd1);
    endtask

    task automatic push_both(input logic [W-1:0] w);
        src[0].push_back(w);
        src[1].push_back(w);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, ".en"}, 64'(en[d]), 64'd0);
            chk({tag, ".num"}, 64'(num[d]), 64'd0);
            chk({tag, ".done"}, 64'(done[d]), 64'd0);
            chk({tag, ".busy"}, 64'(busy[d]), 64'd0);
            chk({tag, ".frame_cnt"}, 64'(fcnt[d]), 64'd0);
            chk({tag, ".in_ready"}, 64'(rdy[d]), 64'd0);
        end
    endtask

    // Called 1 time unit after an edge; asserts reset between edges.
    task automatic apply_reset(input string tag);
        for (int d = 0; d < 2; d++) iv[d] = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs({tag, "_held"});
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk({tag, ".in_ready_release"}, 64'(rdy[d]), 64'd1);
            mrdy[d] = 1'b1;
        end
    endtask

    initial begin
        logic [63:0] r;
        ncmp = 0;
        nfail = 0;
        cyc = 0;
        gate_rand = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0;
            idata[d] = '0;
            ndone[d] = 0;
        end
        model_clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("por.in_ready_release", 64'(rdy[d]), 64'd1);
            mrdy[d] = 1'b1;
        end

        // Single frame
        push_both(40'h0123456789);
        drain(40);

        // Back-to-back frames presented continuously
        push_both(40'hFEDCBA9876);
        push_both(40'h2468ACE024);
        drain(60);

        // Backpressure: three words held valid
        for (int k = 0; k < 3; k++) begin
            r = {$urandom(), $urandom()};
            push_both(r[W-1:0]);
        end
        drain(80);

        // Randomized data with random valid gaps
        gate_rand = 1'b1;
        for (int k = 0; k < 20; k++) begin
            r = {$urandom(), $urandom()};
            push_both(r[W-1:0]);
        end
        drain(600);
        gate_rand = 1'b0;

        // Reset in the middle of a frame with a word queued behind it
        for (int k = 0; k < 2; k++) begin
            r = {$urandom(), $urandom()};
            push_both(r[W-1:0]);
        end
        repeat (7) step();
        for (int d = 0; d < 2; d++) chk("mid.en_before_reset", 64'(en[d]), 64'd1);
        apply_reset("midrst");
        r = {$urandom(), $urandom()};
        push_both(r[W-1:0]);
        drain(40);

        // Counter wrap over 256 frames
        apply_reset("prewrap");
        for (int d = 0; d < 2; d++) ndone[d] = 0;
        for (int k = 0; k < 256; k++) push_both('0);
        drain(4000);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("g%0d.wrap_done_pulses", gap_of(d)), 64'(ndone[d]), 64'd256);
            chk($sformatf("g%0d.wrap_frame_cnt", gap_of(d)), 64'(fcnt[d]), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/nibble_stream_tx.md
# nibble_stream_tx

Frame serializer that takes a packed 40-bit word of ten 4-bit values and drives it out as the `en`/`num` nibble stream consumed by the even-sort block. It is the transmit end of that interface: the sorter packs first-received nibble into bits [39:36], and this block unpacks in the same order. It sits between a word-oriented producer (valid/ready) and any nibble-stream consumer. A one-entry holding buffer and a programmable inter-frame gap give the consumer idle cycles to process between frames.

## Interface
- `NIBBLES`, 10: nibbles per frame; the data width is 4*NIBBLES.
- `GAP`, 4: minimum number of `en`-low cycles after each frame. GAP=0 allows back-to-back frames.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: producer word valid.
- `in_data` input 4*NIBBLES: packed frame; bits [39:36] are sent first.
- `in_ready` output 1: holding buffer empty; a transfer occurs when in_valid && in_ready.
- `en` output 1: nibble strobe, registered.
- `num` output 4: nibble value, registered; 0 whenever en=0.
- `busy` output 1: FSM not in IDLE or holding buffer full.
- `done` output 1: one-cycle pulse on the cycle after the last nibble of a frame.
- `frame_cnt` output 8: completed frames, wraps 255→0.

## Operation
- Storage:
  - `hold` register (4*NIBBLES bits) with `hold_v` flag.
  - `shreg` shift register with nibble counter `idx` (0..NIBBLES-1).
  - `gcnt` gap counter.
- `in_ready = ~hold_v & ~rst`. An accepted word writes `hold` and sets `hold_v` on the next edge.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if `hold_v`, load `shreg` ← `hold`, clear `hold_v`, set idx=0, go to SEND. `en` stays 0 this cycle.
  - SEND: en=1, num=shreg[top nibble]; shift left 4 each cycle and increment idx.
    - After nibble NIBBLES-1: if GAP>0, go to GAP with gcnt=GAP-1.
    - If GAP=0 and `hold_v`, reload `shreg` and stay in SEND (continuous en).
    - Otherwise go to IDLE.
  - GAP: en=0, num=0. Decrement gcnt; at gcnt=0, load from `hold` if `hold_v` and go to SEND, else go to IDLE.
- `done` and `frame_cnt`+1 both occur on the cycle after the last nibble is presented.
- A new word may be accepted during SEND/GAP while `hold_v`=0, so one frame can be queued behind the active one.
- Simultaneous hold→shreg transfer and new acceptance in the same cycle is legal: `hold_v` stays 1 holding the new word.
- Reset values: en=0, num=0, done=0, busy=0, frame_cnt=0, hold_v=0, state=IDLE. in_ready=0 while rst is high, 1 after release.
- Reset mid-frame aborts immediately (asynchronous); the partial frame is not counted and any queued word is discarded.

## Timing
- Accept at edge t (from IDLE, empty): hold_v=1 after t. IDLE loads at t+1; first nibble is visible (en=1) after edge t+2.
- A frame occupies NIBBLES consecutive en-high cycles, followed by exactly GAP en-low cycles whenever the next word is already queued.
- Steady-state throughput with a queued word: one frame per NIBBLES+GAP cycles. With GAP=0, en never drops.
- Extra latency when the word arrives during GAP: none, provided hold_v is set before gcnt reaches 0.

## Structure
- Shared package `nibble_pkg`: NIBBLE_W=4, default NIBBLES=10, FSM state enum {IDLE, SEND, GAP}. Reuse this package in the sort-side receiver.
- One natural sub-module: `nibble_hold_buf`, the single-entry valid/ready holding register with the simultaneous load/drain rule. The FSM, shift register and counters stay in the top module.

## Test plan
- Single frame: in_data=40'h0123456789, GAP=4 → en high for 10 cycles with num=0,1,…,9, first nibble at accept+2; done one cycle after num=9; frame_cnt=1.
- Back-to-back: 40'hFEDCBA9876 then 40'h2468ACE024 presented continuously → second accepted during the first frame; exactly 4 en-low cycles between frames; frame_cnt=2.
- GAP=0 build: two queued words → 20 consecutive en-high cycles carrying F,E,…,6 then 2,4,…,4; done pulses after the 10th and 20th nibbles.
- Backpressure: in_valid held with 3 words while one frame is active → in_ready drops after the second accept and returns only after the hold→shreg transfer; no word lost or duplicated.
- Reset mid-frame: assert rst after the 5th nibble → en=0 and num=0 immediately; frame_cnt=0, in_ready=0 during reset; the next frame after release starts cleanly from nibble 0.
- Counter wrap: 256 frames of 40'h0 → frame_cnt returns to 0, done pulses 256 times.
